// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared pipeline definitions for the fetch and decode stages.
//   - Instruction / address widths and word size in bytes
//   - NOP encoding used for pipeline bubbles
//   - IF/ID register field layout (also reused by the ID-stage register)
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN       = 32;
    localparam int WORD_BYTES = 4;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'd0;

    // IF/ID pipeline register layout
    typedef struct packed {
        logic [XLEN-1:0] pc_next;  // PC+4 of the held instruction
        logic [ILEN-1:0] instr;    // fetched instruction word
        logic            valid;    // 0 marks a bubble
    } if_id_t;

    // Bubble value loaded on reset and on a redirect flush
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc_next = 32'd0;
        b.instr   = NOP_INSTR;
        b.valid   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_stage_inst_mem.sv
// -----------------------------------------------------------------------------
// if_stage_inst_mem
// Word-addressed instruction memory: synchronous write, asynchronous read.
// Byte addresses are mapped to word index addr[AW+1:2]; the upper bits are
// ignored, so addresses alias modulo the memory size. A write and a read of
// the same word in one cycle returns the old word (the write lands on the
// edge, after the combinational read has been captured downstream).
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - byte address for the write
//   wdata  - write word
//   raddr  - byte address for the read
//   rdata  - read word (combinational)
// -----------------------------------------------------------------------------
module if_stage_inst_mem
    import if_stage_pkg::*;
#(
    parameter int IMEM_DEPTH = 256
) (
    input  logic            clk,
    input  logic            we,
    input  logic [XLEN-1:0] waddr,
    input  logic [ILEN-1:0] wdata,
    input  logic [XLEN-1:0] raddr,
    output logic [ILEN-1:0] rdata
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [ILEN-1:0] mem_r [IMEM_DEPTH];
    logic [AW-1:0]   widx_s;
    logic [AW-1:0]   ridx_s;
    logic            unused_addr_bits_s;

    assign widx_s = waddr[AW+1:2];
    assign ridx_s = raddr[AW+1:2];

    // Byte-offset and aliasing bits intentionally take no part in addressing
    assign unused_addr_bits_s = ^{waddr[XLEN-1:AW+2], waddr[1:0],
                                  raddr[XLEN-1:AW+2], raddr[1:0]};

    // Program-load write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[widx_s] <= wdata;
        end
    end

    assign rdata = mem_r[ridx_s];

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage plus the IF/ID pipeline register.
// Per-edge priority: rst > freeze > Br_taken > sequential fetch.
//   - freeze holds PC and IF/ID; a concurrent Br_taken is ignored because its
//     operands may be stale, decode re-asserts it after the stall.
//   - Br_taken redirects PC to the word-aligned target and flushes IF/ID to a
//     bubble, discarding the wrong-path fetch (one-bubble penalty).
// All outputs are driven straight from registers.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   freeze                 - hazard stall from decode
//   Br_taken, Branch_Addr  - redirect request and target byte address
//   imem_we/waddr/wdata    - program-load write port
//   PC_out                 - PC+4 of the instruction in IF/ID
//   Instruction            - instruction in IF/ID
//   valid                  - IF/ID holds a real instruction
//   fetch_pc               - current PC register
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter int              IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            Br_taken,
    input  logic [XLEN-1:0] Branch_Addr,
    input  logic            imem_we,
    input  logic [XLEN-1:0] imem_waddr,
    input  logic [ILEN-1:0] imem_wdata,
    output logic [XLEN-1:0] PC_out,
    output logic [ILEN-1:0] Instruction,
    output logic            valid,
    output logic [XLEN-1:0] fetch_pc
);

    logic [XLEN-1:0] pc_r;
    if_id_t          if_id_r;
    logic [ILEN-1:0] fetch_word_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] redirect_pc_s;
    logic            unused_target_bits_s;

    if_stage_inst_mem #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_inst_mem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc_r),
        .rdata (fetch_word_s)
    );

    // Sequential PC naturally wraps modulo 2^32
    assign pc_plus4_s    = pc_r + 32'd4;
    // Misaligned target bits are dropped rather than trapped
    assign redirect_pc_s = {Branch_Addr[XLEN-1:2], 2'b00};
    assign unused_target_bits_s = ^Branch_Addr[1:0];

    // PC and IF/ID register update with rst > freeze > Br_taken > fetch priority
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            if_id_r <= if_id_bubble();
        end else if (freeze) begin
            pc_r    <= pc_r;
            if_id_r <= if_id_r;
        end else if (Br_taken) begin
            pc_r    <= redirect_pc_s;
            if_id_r <= if_id_bubble();
        end else begin
            pc_r            <= pc_plus4_s;
            if_id_r.pc_next <= pc_plus4_s;
            if_id_r.instr   <= fetch_word_s;
            if_id_r.valid   <= 1'b1;
        end
    end

    assign PC_out      = if_id_r.pc_next;
    assign Instruction = if_id_r.instr;
    assign valid       = if_id_r.valid;
    assign fetch_pc    = pc_r;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage plus the IF/ID pipeline register. It feeds the decode stage with the fetched instruction and PC+4.
- Holds the PC and a word-addressed instruction memory.
- Redirects the PC on a branch taken or jump resolved in decode.
- Holds state on a decode hazard stall.
- Inserts a NOP bubble when a redirect squashes the wrong-path instruction.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two).
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
freeze  input  1  hazard stall from decode (hazard_Detected).
Br_taken  input  1  branch/jump resolved taken in decode this cycle.
Branch_Addr  input  32  redirect target byte address.
imem_we  input  1  instruction memory write enable (program load).
imem_waddr  input  32  byte address for program load.
imem_wdata  input  32  word for program load.
PC_out  output  32  PC+4 of the instruction now in IF/ID.
Instruction  output  32  registered instruction presented to decode.
valid  output  1  IF/ID holds a real (non-bubble) instruction.
fetch_pc  output  32  current PC register, for debug and bench.

Behaviour:
- State: PC (32b); IF/ID register {PC_out, Instruction, valid}.
- Reset, synchronous on rising edge with rst=1:
  - PC=RESET_PC, PC_out=0, Instruction=32'd0 (NOP), valid=0.
  - Memory contents are not reset.
- Per-edge priority, highest first: rst > freeze > Br_taken > normal.
- freeze=1: PC and IF/ID hold their values. Br_taken is ignored because its operands may be stale while a hazard is active. Decode re-asserts Br_taken after the stall.
- Br_taken=1 with freeze=0:
  - PC = {Branch_Addr[31:2], 2'b00}; misaligned low bits are dropped.
  - IF/ID flushed: Instruction=NOP, PC_out=0, valid=0.
  - The instruction fetched this cycle is discarded. Branch penalty is exactly one bubble.
- Normal:
  - PC = PC+4, modulo 2^32; wraps from 32'hFFFF_FFFC to 0.
  - IF/ID loads {PC+4, imem[PC word index], 1}.
- Fetch read is combinational from the PC register, so latency is one edge from PC to IF/ID.
- Word index = PC[log2(IMEM_DEPTH)+1 : 2]. Upper PC bits are ignored, so addresses alias (wrap) modulo the memory size.
- Memory write:
  - imem_we=1 writes imem_wdata at word index of imem_waddr on the edge. Writes are allowed during reset and freeze.
  - Write and fetch to the same word in the same cycle: the fetch sees the old data (read-before-write). The new data is visible from the next cycle.
- Outputs come only from registers; there is no combinational path from freeze or Br_taken to any output.
- Reset asserted mid-stream (including during freeze or Br_taken) wins immediately on that edge. The first fetch after release is from RESET_PC.

Decomposition:
- Shared pipeline package holds:
  - NOP encoding (32'd0).
  - Word size (4).
  - Instruction and address widths (32).
  - IF/ID field layout, reused by the ID-stage register.
- One sub-module: inst_mem, with synchronous write, asynchronous read, parameterised by IMEM_DEPTH.
- PC update logic and the IF/ID register stay in the if_stage top.

Test Plan:
1. Reset and sequential fetch. Load words 0..3 = 32'hA0..A3, rst 2 cycles, release. Required: Instruction = A0, A1, A2, A3 on successive edges; PC_out = 4, 8, 12, 16; valid=1.
2. Stall. Assert freeze for 3 cycles while A1 is in IF/ID. Required: Instruction=A1, PC_out=8 and fetch_pc=8 held for all 3 cycles. A2 appears on the first edge after freeze drops.
3. Redirect. Br_taken=1, Branch_Addr=32'h40 (word 16 = 32'hB0). Required: next edge gives Instruction=0, valid=0, fetch_pc=32'h40; the following edge gives Instruction=B0, PC_out=32'h44.
4. Freeze and branch together. freeze=1, Br_taken=1, Branch_Addr=32'h80. Required: nothing changes. After releasing freeze with Br_taken=1, redirect to 32'h80 occurs.
5. Misaligned target and wrap:
   - Branch_Addr=32'h43 gives fetch_pc=32'h40.
   - Branch_Addr=IMEM_DEPTH*4 fetches word 0.
   - Branch_Addr=32'hFFFF_FFFC, then normal fetch, gives fetch_pc=0.
6. Write/fetch collision and mid-run reset. Write 32'hC0 to the currently fetched word: IF/ID gets the old word, and a refetch gets C0. Assert rst during freeze: next edge gives fetch_pc=RESET_PC, valid=0.
